// File: rtl/muldiv_aludec.sv
// ALU decoder with an iterative HI/LO multiply/divide unit (one bit per cycle).
// Define MULDIV_DIV_EN to include the restoring divider; without it div/divu decode as illegal.
module muldiv_aludec #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [2:0]       alucontrol,
    output logic             mdsel,
    output logic [WIDTH-1:0] mdout,
    output logic             busy,
    output logic             stall,
    output logic             illegal
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef MULDIV_DIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL} state_t;
`endif

    state_t             state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   hi, lo;
    // acc: product high half / partial remainder; qr: multiplier / dividend-quotient
    logic [WIDTH-1:0]   acc, qr, opb;
    logic               neg_res;
`ifdef MULDIV_DIV_EN
    logic               neg_rem;
    logic [WIDTH:0]     div_shift, div_diff;
`endif

    logic rtype, f_mul, f_div, f_mfhi, f_mflo, f_mthi, f_mtlo, hilo_op, alu_funct;
    logic sgn_a, sgn_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] acc_nxt, qr_nxt, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod;

    assign rtype  = (aluop == 2'b10);
    assign f_mul  = rtype && (funct[5:1] == 5'b01100);
`ifdef MULDIV_DIV_EN
    assign f_div  = rtype && (funct[5:1] == 5'b01101);
`else
    assign f_div  = 1'b0;
`endif
    assign f_mfhi = rtype && (funct == 6'b010000);
    assign f_mthi = rtype && (funct == 6'b010001);
    assign f_mflo = rtype && (funct == 6'b010010);
    assign f_mtlo = rtype && (funct == 6'b010011);
    assign hilo_op = f_mul || f_div || f_mfhi || f_mthi || f_mflo || f_mtlo;

    always_comb begin
        alucontrol = 3'b000;
        alu_funct  = 1'b1;
        case (aluop)
            2'b00: alucontrol = 3'b010;
            2'b01: alucontrol = 3'b110;
            2'b11: alucontrol = 3'b111;
            default: begin
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b100110: alucontrol = 3'b100;
                    6'b100111: alucontrol = 3'b101;
                    6'b101010: alucontrol = 3'b111;
                    default: begin
                        alu_funct  = 1'b0;
                        alucontrol = hilo_op ? 3'b010 : 3'b000;
                    end
                endcase
            end
        endcase
    end

    assign illegal = en && rtype && !alu_funct && !hilo_op;
    assign mdsel   = f_mfhi || f_mflo;
    assign mdout   = (funct == 6'b010000) ? hi : lo;
    assign busy    = (state != IDLE);
    assign stall   = en && busy && hilo_op;

    // funct[0] = 0 selects the signed variant of both mult and div
    assign sgn_a = !funct[0] && srca[WIDTH-1];
    assign sgn_b = !funct[0] && srcb[WIDTH-1];
    assign mag_a = sgn_a ? -srca : srca;
    assign mag_b = sgn_b ? -srcb : srcb;

    always_comb begin
        mul_sum = {1'b0, acc} + (qr[0] ? {1'b0, opb} : '0);
        acc_nxt = mul_sum[WIDTH:1];
        qr_nxt  = {mul_sum[0], qr[WIDTH-1:1]};
        prod    = neg_res ? -{acc_nxt, qr_nxt} : {acc_nxt, qr_nxt};
        res_hi  = prod[2*WIDTH-1:WIDTH];
        res_lo  = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        div_shift = {acc, qr[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
        if (state == DIV) begin
            // borrow out of the (WIDTH+1)-bit trial subtract means restore
            acc_nxt = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            qr_nxt  = {qr[WIDTH-2:0], ~div_diff[WIDTH]};
            res_hi  = neg_rem ? -acc_nxt : acc_nxt;
            res_lo  = (opb == '0) ? '1 : (neg_res ? -qr_nxt : qr_nxt);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && (f_mul || f_div)) begin
                        acc     <= '0;
                        qr      <= mag_a;
                        opb     <= mag_b;
                        neg_res <= sgn_a ^ sgn_b;
`ifdef MULDIV_DIV_EN
                        neg_rem <= sgn_a;
                        state   <= f_div ? DIV : MUL;
`else
                        state   <= MUL;
`endif
                        count   <= CW'(WIDTH);
                    end else if (en && f_mthi) begin
                        hi <= srca;
                    end else if (en && f_mtlo) begin
                        lo <= srca;
                    end
                end
                default: begin
                    acc   <= acc_nxt;
                    qr    <= qr_nxt;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= IDLE;
                        hi    <= res_hi;
                        lo    <= res_lo;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_aludec.sv
// Bench for muldiv_aludec: arithmetic reference model checked every cycle plus literal vectors.
module tb_muldiv_aludec;
    localparam int W = 32;
    localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010,
                           F_MTLO = 6'b010011, F_MULT = 6'b011000, F_MULTU = 6'b011001,
                           F_DIV  = 6'b011010, F_DIVU = 6'b011011, F_ADD = 6'b100000;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, en;
    logic [1:0] aluop;
    logic [5:0] funct;
    logic [31:0] srca, srcb;
    logic [2:0] alucontrol;
    logic mdsel, busy, stall, illegal;
    logic [31:0] mdout;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int m_left = 0;

    always #5 clk = ~clk;

    muldiv_aludec #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .en(en), .aluop(aluop), .funct(funct),
        .srca(srca), .srcb(srcb), .alucontrol(alucontrol), .mdsel(mdsel),
        .mdout(mdout), .busy(busy), .stall(stall), .illegal(illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_hilo(input logic [1:0] op, input logic [5:0] f);
        if (op != 2'b10) return 1'b0;
        case (f)
            F_MULT, F_MULTU, F_MFHI, F_MTHI, F_MFLO, F_MTLO: return 1'b1;
            F_DIV, F_DIVU: return DIV_EN;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit is_alu(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100110, 6'b100111, 6'b101010: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] exp_alu(input logic [1:0] op, input logic [5:0] f);
        case (op)
            2'b00: return 3'b010;
            2'b01: return 3'b110;
            2'b11: return 3'b111;
            default: case (f)
                6'b100000: return 3'b010;
                6'b100010: return 3'b110;
                6'b100100: return 3'b000;
                6'b100101: return 3'b001;
                6'b100110: return 3'b100;
                6'b100111: return 3'b101;
                6'b101010: return 3'b111;
                default:   return is_hilo(op, f) ? 3'b010 : 3'b000;
            endcase
        endcase
    endfunction

    // Reference model: whole-result arithmetic, committed after 32 busy cycles
    always @(posedge clk) begin
        logic signed [63:0] sp;
        logic [63:0] up;
        if (reset) begin
            m_left = 0; m_hi = '0; m_lo = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (en && aluop == 2'b10) begin
            case (funct)
                F_MULT: begin
                    sp = $signed({{32{srca[31]}}, srca}) * $signed({{32{srcb[31]}}, srcb});
                    {p_hi, p_lo} = sp; m_left = W;
                end
                F_MULTU: begin
                    up = {32'b0, srca} * {32'b0, srcb};
                    {p_hi, p_lo} = up; m_left = W;
                end
                F_DIV, F_DIVU: if (DIV_EN) begin
                    if (srcb == 0) begin
                        p_lo = '1; p_hi = srca;
                    end else if (funct == F_DIV) begin
                        if (srca == 32'h80000000 && srcb == 32'hFFFFFFFF) begin
                            p_lo = 32'h80000000; p_hi = '0;
                        end else begin
                            p_lo = $signed(srca) / $signed(srcb);
                            p_hi = $signed(srca) % $signed(srcb);
                        end
                    end else begin
                        p_lo = srca / srcb; p_hi = srca % srcb;
                    end
                    m_left = W;
                end
                F_MTHI: m_hi = srca;
                F_MTLO: m_lo = srca;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("alucontrol", alucontrol, exp_alu(aluop, funct));
            chk("illegal", illegal, en && aluop == 2'b10 && !is_alu(funct) && !is_hilo(aluop, funct));
            chk("busy", busy, m_left > 0);
            chk("stall", stall, en && m_left > 0 && is_hilo(aluop, funct));
            chk("mdsel", mdsel, aluop == 2'b10 && (funct == F_MFHI || funct == F_MFLO));
            chk("mdout", mdout, (funct == F_MFHI) ? m_hi : m_lo);
        end
    end

    task automatic step(input logic e, input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        en = e; aluop = op; funct = f; srca = a; srcb = b;
    endtask

    // Present a HI/LO op and hold it until no longer stalled
    task automatic present(input logic [5:0] f, input logic [31:0] a,
                           output int stalls, output logic [31:0] val);
        step(1'b1, 2'b10, f, a, 32'h0);
        stalls = 0;
        @(negedge clk);
        while (stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        chk("stall_release", stall, 1'b0);
        val = mdout;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] v;
        logic [5:0] alu_f [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                   6'b100110, 6'b100111, 6'b101010};
        reset = 1'b1; en = 1'b0; aluop = 2'b00; funct = '0; srca = '0; srcb = '0;
        @(posedge clk); #1;
        chk_on = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        step(1'b1, 2'b10, F_MFLO, 0, 0);
        @(negedge clk);
        chk("reset_mdout", mdout, 32'h0);
        chk("reset_busy", busy, 1'b0);

        for (int i = 0; i < 7; i++) step(1'b1, 2'b10, alu_f[i], 0, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 6'b111111, 0, 0);
        step(1'b1, 2'b10, 6'b100110, 0, 0);
        @(negedge clk);
        chk("xor_alucontrol", alucontrol, 3'b100);
        step(1'b1, 2'b10, 6'b111111, 0, 0);
        @(negedge clk);
        chk("bad_illegal", illegal, 1'b1);
        chk("bad_alucontrol", alucontrol, 3'b000);

        step(1'b1, 2'b10, F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        present(F_MFLO, 0, n, v);
        chk("multu_stalls", n, 32);
        chk("multu_lo", v, 32'h00000001);
        present(F_MFHI, 0, n, v);
        chk("multu_hi", v, 32'hFFFFFFFE);

        step(1'b1, 2'b10, F_MULT, 32'hFFFFFFFD, 32'd5);
        step(1'b1, 2'b10, F_ADD, 1, 2);
        @(negedge clk);
        chk("add_nostall", stall, 1'b0);
        chk("add_busy", busy, 1'b1);
        present(F_MFLO, 0, n, v);
        chk("mult_lo", v, 32'hFFFFFFF1);
        present(F_MFHI, 0, n, v);
        chk("mult_hi", v, 32'hFFFFFFFF);

        step(1'b1, 2'b10, F_MTHI, 32'h12345678, 0);
        step(1'b1, 2'b10, F_MTLO, 32'hCAFEF00D, 0);
        present(F_MFHI, 0, n, v);
        chk("mthi", v, 32'h12345678);
        present(F_MFLO, 0, n, v);
        chk("mtlo", v, 32'hCAFEF00D);

        step(1'b1, 2'b10, F_MULTU, 32'd2, 32'd3);
        present(F_MTHI, 32'hDEADBEEF, n, v);
        chk("mthi_stalls", n, 32);
        present(F_MFHI, 0, n, v);
        chk("stalled_mthi", v, 32'hDEADBEEF);
        present(F_MFLO, 0, n, v);
        chk("mul_lo_kept", v, 32'h00000006);

`ifdef MULDIV_DIV_EN
        step(1'b1, 2'b10, F_DIV, 32'hFFFFFFF9, 32'd2);
        present(F_MFLO, 0, n, v);
        chk("div_q", v, 32'hFFFFFFFD);
        present(F_MFHI, 0, n, v);
        chk("div_r", v, 32'hFFFFFFFF);
        step(1'b1, 2'b10, F_DIVU, 32'd100, 32'd0);
        present(F_MFLO, 0, n, v);
        chk("divu0_q", v, 32'hFFFFFFFF);
        present(F_MFHI, 0, n, v);
        chk("divu0_r", v, 32'h00000064);
        step(1'b1, 2'b10, F_DIV, 32'h80000000, 32'hFFFFFFFF);
        present(F_MFLO, 0, n, v);
        chk("divmin_q", v, 32'h80000000);
        present(F_MFHI, 0, n, v);
        chk("divmin_r", v, 32'h00000000);
        step(1'b1, 2'b10, F_DIV, 32'hFFFFFFF9, 32'd0);
        present(F_MFHI, 0, n, v);
        chk("div0_r", v, 32'hFFFFFFF9);
        step(1'b1, 2'b10, F_DIVU, 32'd1000, 32'd7);
        present(F_MFLO, 0, n, v);
        chk("divu_q", v, 32'd142);
`else
        step(1'b1, 2'b10, F_MTHI, 32'h11111111, 0);
        step(1'b1, 2'b10, F_MTLO, 32'h22222222, 0);
        step(1'b1, 2'b10, F_DIV, 32'd100, 32'd7);
        @(negedge clk);
        chk("nodiv_illegal", illegal, 1'b1);
        chk("nodiv_alucontrol", alucontrol, 3'b000);
        step(1'b1, 2'b10, F_DIVU, 32'd100, 32'd7);
        @(negedge clk);
        chk("nodiv_busy", busy, 1'b0);
        present(F_MFLO, 0, n, v);
        chk("nodiv_lo", v, 32'h22222222);
        present(F_MFHI, 0, n, v);
        chk("nodiv_hi", v, 32'h11111111);
`endif

        step(1'b1, 2'b10, F_MULT, 32'd7, 32'd9);
        for (int i = 0; i < 9; i++) step(1'b0, 2'b00, 6'b0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy_before", busy, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        present(F_MFLO, 0, n, v);
        chk("abort_stalls", n, 0);
        chk("abort_lo", v, 32'h0);
        present(F_MFHI, 0, n, v);
        chk("abort_hi", v, 32'h0);

        step(1'b0, 2'b00, 6'b0, 0, 0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_aludec.md
MULDIV_ALUDEC -- requirements
Module: muldiv_aludec

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width (>= 2).
REQ-002 SHALL have ports: clk  input  1  rising-edge clock.
REQ-003 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have: en  input  1  instruction valid in execute stage.
REQ-005 SHALL have: aluop  input  2  main-decoder op class.
REQ-006 SHALL have: funct  input  6  R-type function field.
REQ-007 SHALL have: srca, srcb  input  WIDTH each  operands (rs, rt).
REQ-008 SHALL have: alucontrol  output  3  ALU operation select.
REQ-009 SHALL have: mdsel  output  1  writeback takes mdout, not ALU result.
REQ-010 SHALL have: mdout  output  WIDTH  HI (mfhi) or LO (mflo).
REQ-011 SHALL have: busy  output  1  multiply/divide iterating.
REQ-012 SHALL have: stall  output  1  hold pipeline this cycle.
REQ-013 SHALL have: illegal  output  1  en with undecodable funct.

Function
REQ-014 alucontrol SHALL be combinational: aluop 00 -> 010; 01 -> 110; 11 -> 111 (slti); 10 -> per funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 100110 (xor) -> 100, 100111 (nor) -> 101, 101010 -> 111.
REQ-015 For aluop 10, funct 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010001 mthi, 010010 mflo, 010011 mtlo SHALL be HI/LO ops; alucontrol = 010 for them.
REQ-016 Any other funct with aluop 10 SHALL give alucontrol 000; illegal = en for that case, else 0.
REQ-017 mdsel = 1 iff aluop 10 and funct is mfhi or mflo; mdout = HI for mfhi, LO otherwise.
REQ-018 State machine SHALL have states IDLE, MUL, DIV; busy = 1 iff state != IDLE.
REQ-019 In IDLE with en and a mult/div funct, the edge SHALL latch operands, sign flag, and counter = WIDTH, and enter MUL or DIV; stall = 0 that cycle.
REQ-020 MUL: shift-add, one bit per cycle; DIV: restoring, one quotient bit per cycle; exactly WIDTH busy cycles, then IDLE.
REQ-021 HI/LO SHALL update only on the final iteration edge; the first cycle with busy = 0 SHALL show the new values.
REQ-022 Signed ops SHALL iterate on magnitudes and correct sign on the final edge: product sign = XOR of operand signs; quotient sign = XOR; remainder sign = dividend sign.
REQ-023 mult/multu: {HI,LO} = 2*WIDTH-bit product.
REQ-024 div/divu: LO = quotient, HI = remainder.
REQ-025 Divide by zero SHALL give LO = all ones, HI = dividend, for both div and divu.
REQ-026 Signed MIN / -1 SHALL give LO = MIN, HI = 0.
REQ-027 mthi/mtlo with en in IDLE SHALL write srca to HI/LO on that edge.
REQ-028 stall = en & busy & (funct is any HI/LO op). Stalled instructions SHALL take no effect; they re-present and are accepted in the first IDLE cycle.
REQ-029 Non-HI/LO instructions SHALL NOT stall while busy.

Reset
REQ-030 reset SHALL force state IDLE, counter 0, HI = LO = 0 on the next edge, including mid-operation; the aborted result is discarded.
REQ-031 reset SHALL take priority over all simultaneous en activity.

Configuration
REQ-032 Macro MULDIV_DIV_EN defined: divider and DIV state SHALL be compiled in, per REQ-020..026.
REQ-033 MULDIV_DIV_EN undefined: DIV state and divider SHALL be absent; div/divu SHALL decode as illegal (alucontrol 000, illegal = en), start nothing, and leave HI/LO unchanged.

Verification (WIDTH = 32)
REQ-034 aluop 10, funct 100110 -> alucontrol 100; en = 1, funct 111111 -> illegal 1, alucontrol 000.
REQ-035 multu 0xFFFFFFFF * 0xFFFFFFFF, then mflo next cycle -> stall 1 for 32 cycles, then HI 0xFFFFFFFE, LO 0x00000001, mdout 0x00000001.
REQ-036 mult -3 * 5 -> HI 0xFFFFFFFF, LO 0xFFFFFFF1; div -7 / 2 -> LO 0xFFFFFFFD, HI 0xFFFFFFFF.
REQ-037 divu 100 / 0 -> LO 0xFFFFFFFF, HI 0x00000064; div 0x80000000 / 0xFFFFFFFF -> LO 0x80000000, HI 0.
REQ-038 reset asserted on busy cycle 10 of a mult -> next cycle busy 0, HI = LO = 0; mflo then not stalled, mdout 0.
REQ-039 Build without MULDIV_DIV_EN: div with en -> illegal 1, busy stays 0, HI/LO unchanged.
